dma_priority_arbiter: RTL and testbench

- Parametrised N-channel request arbiter and bus-hold sequencer for the DMA controller. Generalises the fixed 4-channel priority logic.
- Merges hardware DREQ and software requests per channel and applies masks. Arbitrates using fixed or rotating priority.
- Runs the HRQ/HLDA hold handshake and drives one-hot DACK.
- Releases the bus according to each channel's transfer mode (demand/single/block). The timing-control FSM consumes activeChannel and grantValid.

---
 rtl/dma_priority_arbiter.sv | 96 +++++++++
 tb/tb_dma_priority_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: N-channel DMA request arbiter with HRQ/HLDA hold sequencing and mode-based bus release
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int RELEASE_CYCLES = 1,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [NUM_CH-1:0]   DREQ,
    input  logic                dreqActiveLow,
    input  logic                priorityType,
    input  logic [NUM_CH-1:0]   maskReg,
    input  logic [NUM_CH-1:0]   swRequestSet,
    input  logic [2*NUM_CH-1:0] modeSel,
    input  logic                HLDA,
    input  logic                transferDone,
    input  logic                eop,
    output logic                HRQ,
    output logic [NUM_CH-1:0]   DACK,
    output logic                grantValid,
    output logic [CH_W-1:0]     activeChannel,
    output logic [NUM_CH-1:0]   requestStatus
);
    localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, GRANT = 2'd2, RELEASE = 2'd3;
    logic [1:0]        state;
    logic [CH_W-1:0]   top_ch;
    logic [CH_W-1:0]   winner;
    logic [CH_W-1:0]   next_top;
    logic [CNT_W-1:0]  rel_cnt;
    logic [NUM_CH-1:0] eff;
    logic [NUM_CH-1:0] act_oh;
    logic [NUM_CH-1:0] clr;
    logic [1:0]        mode;
    logic              release_now;
    int                idx;
    assign eff = ((DREQ ^ {NUM_CH{dreqActiveLow}}) | requestStatus) & ~maskReg;
    assign mode = modeSel[{activeChannel, 1'b0} +: 2];
    assign release_now = eop | (transferDone & (mode[0] | (mode == 2'b00 & ~eff[activeChannel])));
    assign next_top = (int'(activeChannel) == NUM_CH - 1) ? '0 : activeChannel + 1'b1;
    assign clr = (state == GRANT && HLDA && eop) ? act_oh : '0;
    assign HRQ = (state == REQ) || (state == GRANT);
    assign DACK = (state == GRANT) ? act_oh : '0;
    assign grantValid = |DACK;
    // one-hot decode of the granted channel
    always_comb begin
        act_oh = '0;
        act_oh[activeChannel] = 1'b1;
    end
    // scan from highest to lowest search offset so the first hit in priority order is the last written
    always_comb begin
        winner = '0;
        idx = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = priorityType ? int'(top_ch) + k : k;
            idx = (idx >= NUM_CH) ? idx - NUM_CH : idx;
            if (eff[idx]) winner = CH_W'(idx);
        end
    end
    // hold-request sequencer: idle -> request -> grant -> release
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            activeChannel <= '0;
            top_ch <= '0;
            rel_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rel_cnt != '0) rel_cnt <= rel_cnt - 1'b1;
                    else if (|eff) state <= REQ;
                end
                REQ: begin
                    if (HLDA) begin
                        state <= (|eff) ? GRANT : IDLE;
                        if (|eff) activeChannel <= winner;
                    end
                end
                GRANT: begin
                    if (!HLDA) state <= IDLE;
                    else if (release_now) begin
                        state <= RELEASE;
                        rel_cnt <= CNT_W'(RELEASE_CYCLES - 1);
                        if (priorityType) top_ch <= next_top;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // software request latches; a new set beats a simultaneous eop clear
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) requestStatus <= '0;
        else requestStatus <= (requestStatus & ~clr) | swRequestSet;
    end
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: directed and random checks of the DMA arbiter against a behavioural model
module tb_dma_priority_arbiter;
    localparam int N = 4;
    localparam int RC = 1;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    logic [N-1:0] dreq, mask, swset, dack, rs;
    logic [2*N-1:0] mode;
    logic dal, prio, hlda, td, eop, hrq, gv;
    logic [1:0] ac;
    logic [5:0] dreq6, dack6, rs6;
    logic [2:0] ac6;
    logic hrq6, gv6, td6;
    int checks = 0, errors = 0;
    int ph, act, top, cnt;
    logic [N-1:0] mrs;
    logic auto_h;

    dma_priority_arbiter #(.NUM_CH(N), .RELEASE_CYCLES(RC)) dut (
        .CLK(clk), .RESET_N(rst_n), .DREQ(dreq), .dreqActiveLow(dal), .priorityType(prio),
        .maskReg(mask), .swRequestSet(swset), .modeSel(mode), .HLDA(hlda), .transferDone(td),
        .eop(eop), .HRQ(hrq), .DACK(dack), .grantValid(gv), .activeChannel(ac), .requestStatus(rs)
    );

    dma_priority_arbiter #(.NUM_CH(6), .RELEASE_CYCLES(1)) dut6 (
        .CLK(clk), .RESET_N(rst_n), .DREQ(dreq6), .dreqActiveLow(1'b1), .priorityType(1'b1),
        .maskReg(6'b0), .swRequestSet(6'b0), .modeSel(12'b010101010101), .HLDA(1'b1),
        .transferDone(td6), .eop(1'b0), .HRQ(hrq6), .DACK(dack6), .grantValid(gv6),
        .activeChannel(ac6), .requestStatus(rs6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] m_eff();
        return ((dreq ^ {N{dal}}) | mrs) & ~mask;
    endfunction

    function automatic int m_pick(input logic [N-1:0] e);
        for (int k = 0; k < N; k++) begin
            int c;
            c = prio ? (top + k) % N : k;
            if (e[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_reset();
        ph = 0; act = 0; top = 0; cnt = 0; mrs = '0;
    endtask

    // phases: 0 idle, 1 requesting, 2 granted, 3 releasing
    task automatic model_step();
        logic [N-1:0] e, clr;
        int md;
        e = m_eff();
        clr = '0;
        case (ph)
            0: if (cnt > 0) cnt--; else if (e != 0) ph = 1;
            1: if (hlda) begin
                if (e == 0) ph = 0;
                else begin act = m_pick(e); ph = 2; end
            end
            2: if (!hlda) ph = 0;
            else begin
                md = int'((mode >> (2 * act)) & 8'd3);
                if (eop || (td && md != 2 && (md != 0 || !e[act]))) begin
                    ph = 3;
                    cnt = RC - 1;
                    if (prio) top = (act + 1) % N;
                    if (eop) clr[act] = 1'b1;
                end
            end
            default: ph = 0;
        endcase
        mrs = (mrs & ~clr) | swset;
    endtask

    task automatic check_all();
        chk("hrq", hrq, ph == 1 || ph == 2);
        chk("dack", dack, ph == 2 ? (1 << act) : 0);
        chk("grant_valid", gv, ph == 2);
        chk("active_channel", ac, act);
        chk("request_status", rs, mrs);
        chk("top_ch", dut.top_ch, top);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
        if (auto_h) hlda = (ph == 1 || ph == 2);
        swset = '0; td = 0; eop = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        hlda = 0; dreq = '0; mask = '0; swset = '0; td = 0; eop = 0;
        dreq6 = 6'b111111; td6 = 0;
        repeat (2) tick();
        chk("rst_hrq", hrq, 0);
        chk("rst_dack", dack, 0);
        chk("rst_rs", rs, 0);
        rst_n = 1;
    endtask

    task automatic wait_grant(input int exp, input string tag);
        int n = 0;
        while (!gv && n < 30) begin tick(); n++; end
        chk({tag, "_timeout"}, gv, 1);
        chk({tag, "_ch"}, ac, exp);
        chk({tag, "_dack"}, dack, 1 << exp);
    endtask

    task automatic wait6(input int exp, input string tag);
        int n = 0;
        while (!gv6 && n < 30) begin tick(); n++; end
        chk({tag, "_timeout"}, gv6, 1);
        chk({tag, "_ch"}, ac6, exp);
        chk({tag, "_dack"}, dack6, 1 << exp);
    endtask

    initial begin
        rst_n = 0; dal = 0; prio = 0; mode = 8'b01010101; auto_h = 1;
        hlda = 0; dreq = '0; mask = '0; swset = '0; td = 0; eop = 0;
        dreq6 = 6'b111111; td6 = 0;
        model_reset();
        do_reset();
        // fixed priority, all channels requesting, each drops after service
        dreq = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_grant(i, "fixed");
            dreq[i] = 1'b0;
            td = 1;
            tick();
            chk("fixed_release_hrq", hrq, 0);
        end
        // rotating priority with requests held
        do_reset();
        prio = 1; dreq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(i % 4, "rotate");
            td = 1;
            tick();
            if (i == 2) chk("rotate_top_after_ch2", dut.top_ch, 3);
        end
        // demand mode on ch1
        prio = 0; mode = 8'b01_01_00_01; dreq = 4'b0010;
        wait_grant(1, "demand");
        td = 1; tick();
        chk("demand_hold", gv, 1);
        dreq = '0; td = 1; tick();
        chk("demand_release", gv, 0);
        // block mode on ch3 releases only on eop
        mode = 8'b10_01_00_01; dreq = 4'b1000;
        wait_grant(3, "block");
        for (int i = 0; i < 5; i++) begin
            td = 1; tick();
            chk("block_hold", gv, 1);
        end
        eop = 1; tick();
        chk("block_eop_release", gv, 0);
        dreq = '0;
        // software request latch
        mode = 8'b01010101;
        repeat (3) tick();
        swset = 4'b0100; tick();
        chk("sw_set", rs, 4'b0100);
        wait_grant(2, "sw");
        repeat (3) tick();
        chk("sw_latched", rs, 4'b0100);
        eop = 1; tick();
        chk("sw_cleared", rs, 4'b0000);
        repeat (3) tick();
        mask = 4'b0100; swset = 4'b0100; tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("masked_hrq", hrq, 0);
        end
        // HLDA abort and asynchronous reset mid-grant
        do_reset();
        prio = 1; dreq = 4'b0001;
        wait_grant(0, "abort");
        auto_h = 0; hlda = 0; tick();
        chk("abort_dack", dack, 0);
        chk("abort_hrq", hrq, 0);
        chk("abort_top", dut.top_ch, 0);
        auto_h = 1;
        wait_grant(0, "regrant");
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("async_rst_hrq", hrq, 0);
        chk("async_rst_dack", dack, 0);
        chk("async_rst_gv", gv, 0);
        chk("async_rst_ac", ac, 0);
        do_reset();
        // six channels, active-low DREQ, rotating wrap
        dreq6 = 6'b111110;
        wait6(0, "n6_first");
        td6 = 1; tick(); td6 = 0;
        chk("n6_top", dut6.top_ch, 1);
        dreq6 = 6'b011110;
        wait6(5, "n6_ch5");
        td6 = 1; tick(); td6 = 0;
        wait6(0, "n6_wrap");
        td6 = 1; tick(); td6 = 0;
        dreq6 = 6'b111111;
        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            dreq = N'($urandom);
            dal = ($urandom % 8 == 0) ? ~dal : dal;
            prio = ($urandom % 16 == 0) ? ~prio : prio;
            mask = ($urandom % 4 == 0) ? N'($urandom) : '0;
            swset = ($urandom % 8 == 0) ? N'($urandom) : '0;
            mode = ($urandom % 8 == 0) ? (2*N)'($urandom) : mode;
            td = ($urandom % 4 == 0);
            eop = ($urandom % 10 == 0);
            hlda = hlda ^ ($urandom % 16 == 0);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
